tlb_port_scheduler: RTL and testbench

//  Sequences the single shared TLB search/read/write port between the instruction MMU, the data MMU
//  and the TLBP/TLBR/TLBWI/TLBWR maintenance ops from PREMEM.

---
 rtl/tlb_port_scheduler.sv | 178 +++++++++++++++++
 tb/tb_tlb_port_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tlb_port_scheduler.sv
// Shared TLB port scheduler: arbitrates inst/data/TLBP lookups and
// sequences TLBWI/TLBWR and TLBR with drain and post-write blackout.
//
// Ports:
//   clk, rst (sync, active-low)
//   i_*  : inst MMU lookup req/key, grant and response-valid
//   d_*  : data MMU lookup req/key, grant and response-valid
//   p_*  : TLBP search req/key, grant and response-valid
//   asid_i        : ASID applied to every lookup
//   wr_req_i/ack  : TLB write handshake (level req, 1-cycle ack)
//   rd_req_i/ack  : TLB read handshake (level req, 1-cycle ack)
//   tlb_*         : lookup strobe/key and write/read enables to the TLB
//   busy_o        : scheduler is in a maintenance state
module tlb_port_scheduler #(
  parameter int VPN2_W       = 19,
  parameter int ASID_W       = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int WR_HOLD      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_i,
  input  logic [VPN2_W-1:0] i_vpn2_i,
  input  logic              i_odd_i,
  output logic              i_gnt_o,
  output logic              i_rsp_vld_o,
  input  logic              d_req_i,
  input  logic [VPN2_W-1:0] d_vpn2_i,
  input  logic              d_odd_i,
  output logic              d_gnt_o,
  output logic              d_rsp_vld_o,
  input  logic              p_req_i,
  input  logic [VPN2_W-1:0] p_vpn2_i,
  output logic              p_gnt_o,
  output logic              p_rsp_vld_o,
  input  logic [ASID_W-1:0] asid_i,
  input  logic              wr_req_i,
  output logic              wr_ack_o,
  input  logic              rd_req_i,
  output logic              rd_ack_o,
  output logic              tlb_req_o,
  output logic [VPN2_W-1:0] tlb_vpn2_o,
  output logic              tlb_odd_o,
  output logic [ASID_W-1:0] tlb_asid_o,
  output logic              tlb_w_en_o,
  output logic              tlb_r_en_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    RUN,
    DRAIN,
    WRITE,
    HOLD,
    READ,
    RDATA
  } state_t;

  localparam logic [3:0] SLIM  = 4'(STARVE_LIMIT);
  localparam logic [1:0] HLAST = 2'(WR_HOLD - 1);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic [1:0]  hold_cnt;
  logic        own_i;
  logic        own_d;
  logic        own_p;

  logic        run;
  logic        starved;
  logic        gi;
  logic        gd;
  logic        gp;
  logic [VPN2_W-1:0] key_vpn2;
  logic        key_odd;

  // Maintenance requests seen in RUN already block this cycle's grants.
  assign run = rst && (state == RUN)
            && !wr_req_i && !rd_req_i;
  assign starved = (starve_cnt == SLIM);

  // TLBP always first; a starved inst
  // overtakes data but never TLBP.
  always_comb begin
    gp = 1'b0;
    gd = 1'b0;
    gi = 1'b0;
    if (run) begin
      priority case (1'b1)
        p_req_i:              gp = 1'b1;
        (i_req_i && starved): gi = 1'b1;
        d_req_i:              gd = 1'b1;
        i_req_i:              gi = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    key_vpn2 = '0;
    key_odd  = 1'b0;
    unique case (1'b1)
      gp: key_vpn2 = p_vpn2_i;
      gd: begin
        key_vpn2 = d_vpn2_i;
        key_odd  = d_odd_i;
      end
      gi: begin
        key_vpn2 = i_vpn2_i;
        key_odd  = i_odd_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      starve_cnt <= '0;
      hold_cnt   <= '0;
      own_i      <= 1'b0;
      own_d      <= 1'b0;
      own_p      <= 1'b0;
    end else begin
      own_i <= gi;
      own_d <= gd;
      own_p <= gp;
      if (!i_req_i || gi)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + 4'd1;
      unique case (state)
        RUN:
          if (wr_req_i || rd_req_i)
            state <= DRAIN;
        DRAIN:
          state <= wr_req_i ? WRITE : READ;
        WRITE: begin
          state    <= HOLD;
          hold_cnt <= '0;
        end
        HOLD:
          if (hold_cnt == HLAST)
            state <= RUN;
          else
            hold_cnt <= hold_cnt + 2'd1;
        READ:
          state <= RDATA;
        RDATA:
          state <= RUN;
        default:
          state <= RUN;
      endcase
    end
  end

  // Every output is forced low while reset is held so that a
  // pending write or in-flight result never escapes.
  assign i_gnt_o     = gi;
  assign d_gnt_o     = gd;
  assign p_gnt_o     = gp;
  assign i_rsp_vld_o = rst && own_i;
  assign d_rsp_vld_o = rst && own_d;
  assign p_rsp_vld_o = rst && own_p;

  assign tlb_req_o  = gi || gd || gp;
  assign tlb_vpn2_o = key_vpn2;
  assign tlb_odd_o  = key_odd;
  assign tlb_asid_o = rst ? asid_i : '0;

  assign tlb_w_en_o = rst && (state == WRITE);
  assign tlb_r_en_o = rst && (state == READ);
  assign wr_ack_o   = rst && (state == HOLD)
                   && (hold_cnt == HLAST);
  assign rd_ack_o   = rst && (state == RDATA);
  assign busy_o     = rst && (state != RUN);

endmodule

// File: tb/tb_tlb_port_scheduler.sv
// Testbench for tlb_port_scheduler: per-cycle vector table plus
// hand-written write/read latency sequences.
module tb_tlb_port_scheduler;

  localparam int VW = 19;
  localparam int AW = 8;
  localparam logic [VW-1:0] IV = 19'h1A1A1;
  localparam logic [VW-1:0] DV = 19'h2B2B2;
  localparam logic [VW-1:0] PV = 19'h3C3C3;
  localparam logic [AW-1:0] AS = 8'h5A;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, p_req = 1'b0;
  logic wr = 1'b0, rd = 1'b0;
  logic i_gnt, d_gnt, p_gnt;
  logic i_rsp, d_rsp, p_rsp;
  logic wr_ack, rd_ack, t_req, t_odd, w_en, r_en, busy;
  logic [VW-1:0] t_vpn2;
  logic [AW-1:0] t_asid;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  tlb_port_scheduler dut (
    .clk(clk), .rst(rst),
    .i_req_i(i_req), .i_vpn2_i(IV), .i_odd_i(1'b1),
    .i_gnt_o(i_gnt), .i_rsp_vld_o(i_rsp),
    .d_req_i(d_req), .d_vpn2_i(DV), .d_odd_i(1'b1),
    .d_gnt_o(d_gnt), .d_rsp_vld_o(d_rsp),
    .p_req_i(p_req), .p_vpn2_i(PV),
    .p_gnt_o(p_gnt), .p_rsp_vld_o(p_rsp),
    .asid_i(AS),
    .wr_req_i(wr), .wr_ack_o(wr_ack),
    .rd_req_i(rd), .rd_ack_o(rd_ack),
    .tlb_req_o(t_req), .tlb_vpn2_o(t_vpn2),
    .tlb_odd_o(t_odd), .tlb_asid_o(t_asid),
    .tlb_w_en_o(w_en), .tlb_r_en_o(r_en),
    .busy_o(busy)
  );

  // req/gnt/rsp bit order {p,d,i};
  // ctl = {w_en,r_en,wr_ack,rd_ack,busy}
  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       wr;
    logic       rd;
    logic [2:0] gnt;
    logic [2:0] rsp;
    logic [4:0] ctl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    logic r, logic [2:0] q, logic w, logic d,
    logic [2:0] g, logic [2:0] s, logic [4:0] c);
    vec_t x;
    x.rst = r; x.req = q; x.wr = w; x.rd = d;
    x.gnt = g; x.rsp = s; x.ctl = c;
    return x;
  endfunction

  task automatic chk(string name, logic [63:0] got,
                     logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] expect_word(vec_t x);
    logic [VW-1:0] ev;
    logic eo;
    ev = '0;
    eo = 1'b0;
    if (x.gnt == 3'b100) ev = PV;
    if (x.gnt == 3'b010) begin ev = DV; eo = 1'b1; end
    if (x.gnt == 3'b001) begin ev = IV; eo = 1'b1; end
    return 64'({x.gnt, x.rsp, x.ctl, |x.gnt, ev, eo,
                x.rst ? AS : 8'h00});
  endfunction

  function automatic logic [63:0] actual_word();
    return 64'({p_gnt, d_gnt, i_gnt, p_rsp, d_rsp, i_rsp,
                w_en, r_en, wr_ack, rd_ack, busy,
                t_req, t_vpn2, t_odd, t_asid});
  endfunction

  task automatic lat(input bit is_wr, input string name,
                     input int exp_n);
    int n;
    int pulses;
    bit seen;
    n = 0;
    pulses = 0;
    seen = 1'b0;
    @(posedge clk);
    #1;
    wr = is_wr;
    rd = !is_wr;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      n++;
      if (is_wr ? w_en : r_en) pulses++;
      if (is_wr ? wr_ack : rd_ack) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
    chk({name, "_lat"}, 64'(seen ? n : -1), 64'(exp_n));
    chk({name, "_en_pulses"}, 64'(pulses), 64'd1);
  endtask

  initial begin
    // reset: outputs quiet even with requests present
    tbl.push_back(v(0, 3'b000, 0, 0, 3'b000, 3'b000, 5'b00000));
    tbl.push_back(v(0, 3'b011, 0, 0, 3'b000, 3'b000, 5'b00000));
    // starvation: d wins 4 cycles, then inst
    tbl.push_back(v(1, 3'b011, 0, 0, 3'b010, 3'b000, 5'b00000));
    tbl.push_back(v(1, 3'b011, 0, 0, 3'b010, 3'b010, 5'b00000));
    tbl.push_back(v(1, 3'b011, 0, 0, 3'b010, 3'b010, 5'b00000));
    tbl.push_back(v(1, 3'b011, 0, 0, 3'b010, 3'b010, 5'b00000));
    tbl.push_back(v(1, 3'b011, 0, 0, 3'b001, 3'b010, 5'b00000));
    tbl.push_back(v(1, 3'b010, 0, 0, 3'b010, 3'b001, 5'b00000));
    tbl.push_back(v(1, 3'b000, 0, 0, 3'b000, 3'b010, 5'b00000));
    // TLBP beats all, odd forced 0
    tbl.push_back(v(1, 3'b111, 0, 0, 3'b100, 3'b000, 5'b00000));
    tbl.push_back(v(1, 3'b011, 0, 0, 3'b010, 3'b100, 5'b00000));
    tbl.push_back(v(1, 3'b000, 0, 0, 3'b000, 3'b010, 5'b00000));
    // inst alone: granted every cycle
    tbl.push_back(v(1, 3'b001, 0, 0, 3'b001, 3'b000, 5'b00000));
    tbl.push_back(v(1, 3'b001, 0, 0, 3'b001, 3'b001, 5'b00000));
    tbl.push_back(v(1, 3'b001, 0, 0, 3'b001, 3'b001, 5'b00000));
    tbl.push_back(v(1, 3'b000, 0, 0, 3'b000, 3'b001, 5'b00000));
    // d grant then write: drain, write, hold, resume
    tbl.push_back(v(1, 3'b010, 0, 0, 3'b010, 3'b000, 5'b00000));
    tbl.push_back(v(1, 3'b010, 1, 0, 3'b000, 3'b010, 5'b00000));
    tbl.push_back(v(1, 3'b010, 1, 0, 3'b000, 3'b000, 5'b00001));
    tbl.push_back(v(1, 3'b010, 1, 0, 3'b000, 3'b000, 5'b10001));
    tbl.push_back(v(1, 3'b010, 1, 0, 3'b000, 3'b000, 5'b00101));
    tbl.push_back(v(1, 3'b010, 0, 0, 3'b010, 3'b000, 5'b00000));
    tbl.push_back(v(1, 3'b000, 0, 0, 3'b000, 3'b010, 5'b00000));
    // write+read together, inst starving throughout
    tbl.push_back(v(1, 3'b001, 1, 1, 3'b000, 3'b000, 5'b00000));
    tbl.push_back(v(1, 3'b001, 1, 1, 3'b000, 3'b000, 5'b00001));
    tbl.push_back(v(1, 3'b001, 1, 1, 3'b000, 3'b000, 5'b10001));
    tbl.push_back(v(1, 3'b001, 1, 1, 3'b000, 3'b000, 5'b00101));
    tbl.push_back(v(1, 3'b001, 0, 1, 3'b000, 3'b000, 5'b00000));
    tbl.push_back(v(1, 3'b001, 0, 1, 3'b000, 3'b000, 5'b00001));
    tbl.push_back(v(1, 3'b001, 0, 1, 3'b000, 3'b000, 5'b01001));
    tbl.push_back(v(1, 3'b001, 0, 1, 3'b000, 3'b000, 5'b00011));
    tbl.push_back(v(1, 3'b011, 0, 0, 3'b001, 3'b000, 5'b00000));
    tbl.push_back(v(1, 3'b010, 0, 0, 3'b010, 3'b001, 5'b00000));
    tbl.push_back(v(1, 3'b000, 0, 0, 3'b000, 3'b010, 5'b00000));
    // reset during write-pending drain: write never issued
    tbl.push_back(v(1, 3'b000, 1, 0, 3'b000, 3'b000, 5'b00000));
    tbl.push_back(v(0, 3'b000, 1, 0, 3'b000, 3'b000, 5'b00000));
    tbl.push_back(v(1, 3'b000, 0, 0, 3'b000, 3'b000, 5'b00000));
    // reset drops an in-flight result
    tbl.push_back(v(1, 3'b010, 0, 0, 3'b010, 3'b000, 5'b00000));
    tbl.push_back(v(0, 3'b000, 0, 0, 3'b000, 3'b000, 5'b00000));
    tbl.push_back(v(1, 3'b000, 0, 0, 3'b000, 3'b000, 5'b00000));

    foreach (tbl[n]) begin
      @(posedge clk);
      #1;
      rst   = tbl[n].rst;
      p_req = tbl[n].req[2];
      d_req = tbl[n].req[1];
      i_req = tbl[n].req[0];
      wr    = tbl[n].wr;
      rd    = tbl[n].rd;
      @(negedge clk);
      chk($sformatf("vec%0d", n), actual_word(),
          expect_word(tbl[n]));
    end

    lat(1'b1, "write", 4);
    lat(1'b0, "read", 4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
